// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store responder: turns one memRead/memWrite per instruction into a
// req/ack data-bus transaction, with byte enables, load formatting, fault and timeout handling.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;

  logic        req, legal, size_ok, align_ok, timeout_hit;
  logic [15:0] cnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx, lane, load_fmt;

  // Decode of the incoming access; only meaningful while in IDLE.
  always_comb begin
    req = memRead | memWrite;
    if (memWrite) size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = size_ok & align_ok;
    case (funct3[1:0])
      2'b00: begin
        be_nx = 4'b0001 << addr[1:0];
        wd_nx = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_nx = 4'b0011 << {addr[1], 1'b0};
        wd_nx = {2{wdata[15:0]}};
      end
      default: begin
        be_nx = 4'b1111;
        wd_nx = wdata;
      end
    endcase
  end

  // Load formatting uses the offset/size latched at request time, not the live inputs.
  always_comb begin
    lane = bus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_fmt = {24'h0, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_fmt = {16'h0, lane[15:0]};
      default: load_fmt = bus_rdata;
    endcase
  end

  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    bus_req  = 1'b0;
    case (state)
      IDLE: begin
        stall = req & legal;
        if (req) state_nx = legal ? REQ : DONE;
      end
      REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || timeout_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      rdata     <= '0;
      fault     <= 1'b0;
      bus_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      fault   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            if (legal) begin
              bus_we    <= memWrite;
              bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              bus_be    <= be_nx;
              bus_wdata <= wd_nx;
              off_q     <= addr[1:0];
              f3_q      <= funct3;
            end else begin
              fault <= 1'b1;
              rdata <= '0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (bus_ack) begin
            if (!bus_we) rdata <= load_fmt;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            rdata   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: loads, stores, fault, timeout and reset-in-REQ.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, memRead, memWrite, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, bus_rdata;
  logic        stall, fault, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  int total = 0;
  int bad   = 0;

  data_mem_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .fault(fault),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction with ack in the first REQ cycle.
  task automatic xfer(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd);
    memRead = ~wr; memWrite = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk({tag, ".stall_idle"}, stall, 1);
    chk({tag, ".noreq_idle"}, bus_req, 0);
    tick();
    chk({tag, ".req"}, bus_req, 1);
    chk({tag, ".stall_req"}, stall, 1);
    chk({tag, ".we"}, bus_we, wr);
    chk({tag, ".addr"}, bus_addr, a & 32'hFFFF_FFFC);
    chk({tag, ".be"}, bus_be, exp_be);
    if (wr) chk({tag, ".wdata"}, bus_wdata, exp_wd);
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    chk({tag, ".stall_done"}, stall, 0);
    chk({tag, ".req_done"}, bus_req, 0);
    if (!wr) chk({tag, ".rdata"}, rdata, exp_rd);
    tick();
    chk({tag, ".stall_after"}, stall, 0);
    if (!wr) chk({tag, ".rdata_held"}, rdata, exp_rd);
  endtask

  initial begin
    int n;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; bus_ack = 1'b0;
    funct3 = 3'b0; addr = '0; wdata = '0; bus_rdata = '0;
    tick(); tick();
    chk("rst.stall", stall, 0);
    chk("rst.req", bus_req, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.fault", fault, 0);
    chk("rst.bus_err", bus_err, 0);
    chk("rst.be", bus_be, 0);
    rst = 1'b0;
    tick();

    xfer("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    xfer("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80);
    xfer("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 4'b1000, 32'h0, 32'h00000080);
    xfer("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h9ABC1234, 4'b1100, 32'h0, 32'hFFFF9ABC);
    xfer("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h9ABC8765, 4'b0011, 32'h0, 32'h00008765);
    xfer("sh",  1'b1, 3'b001, 32'h0A,  32'h0000ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    xfer("sb",  1'b1, 3'b000, 32'h21,  32'h123456EF, 32'h0, 4'b0010, 32'hEFEFEFEF, 32'h0);
    chk("store.rdata_kept", rdata, 32'h00008765);

    // Misaligned word: fault pulse, no bus, rdata cleared.
    memRead = 1'b1; funct3 = 3'b010; addr = 32'h102;
    #1;
    chk("mis.stall_idle", stall, 0);
    tick();
    chk("mis.fault", fault, 1);
    chk("mis.req", bus_req, 0);
    chk("mis.stall_done", stall, 0);
    chk("mis.rdata", rdata, 0);
    memRead = 1'b0;
    tick();
    chk("mis.fault_pulse", fault, 0);

    // Store with a load-only funct3 is illegal.
    memWrite = 1'b1; funct3 = 3'b100; addr = 32'h40;
    tick();
    chk("sbu.fault", fault, 1);
    chk("sbu.req", bus_req, 0);
    memWrite = 1'b0;
    tick();

    xfer("lw2", 1'b0, 3'b010, 32'h200, 32'h0, 32'h5A5A0001, 4'b1111, 32'h0, 32'h5A5A0001);

    // Timeout with TIMEOUT=4.
    memRead = 1'b1; funct3 = 3'b010; addr = 32'h300;
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus_req) break;
      n++;
      tick();
    end
    chk("to.req_cycles", n, 4);
    chk("to.bus_err", bus_err, 1);
    chk("to.stall", stall, 0);
    chk("to.rdata", rdata, 0);
    memRead = 1'b0;
    tick();
    chk("to.err_pulse", bus_err, 0);

    xfer("lw3", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);

    // Reset while in REQ; the late ack must be ignored.
    memRead = 1'b1; funct3 = 3'b010; addr = 32'h500;
    tick();
    chk("rr.req", bus_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; memRead = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEBABE;
    #1;
    chk("rr.req_drop", bus_req, 0);
    chk("rr.rdata_rst", rdata, 0);
    tick();
    bus_ack = 1'b0;
    chk("rr.rdata", rdata, 0);
    chk("rr.req_after", bus_req, 0);
    memRead = 1'b1; addr = 32'h600;
    #1;
    chk("rr.idle_stall", stall, 1);
    tick();
    chk("rr.new_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
    tick();
    bus_ack = 1'b0; memRead = 1'b0;
    chk("rr.new_rdata", rdata, 32'h13579BDF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
